// File: rtl/sync_align_if.sv
// Bundle of the offset-stage handshake, the incoming ECG sample stream and
// the aligned-frame outputs of sync_align. The block itself sits on the
// slave side; whatever feeds and observes it uses the master side.
interface sync_align_if #(
    parameter int DATA_W      = 16,
    parameter int LOG2_WIN    = 10,
    parameter int FRAME_CNT_W = 8
);
    // Offset stage handshake
    logic                       offset_vld;
    logic [DATA_W-1:0]          offset_i;

    // Raw sample stream
    logic                       data_vld_i;
    logic signed [DATA_W-1:0]   data_i;

    // Aligned frame stream and status
    logic                       data_vld_o;
    logic signed [DATA_W-1:0]   data_o;
    logic                       frame_start_o;
    logic                       frame_end_o;
    logic [LOG2_WIN-1:0]        sample_idx_o;
    logic [FRAME_CNT_W-1:0]     frame_cnt_o;
    logic                       align_busy_o;
    logic                       align_done_o;
    logic                       offset_err_o;

    modport master (
        output offset_vld, offset_i, data_vld_i, data_i,
        input  data_vld_o, data_o, frame_start_o, frame_end_o, sample_idx_o,
               frame_cnt_o, align_busy_o, align_done_o, offset_err_o
    );

    modport slave (
        input  offset_vld, offset_i, data_vld_i, data_i,
        output data_vld_o, data_o, frame_start_o, frame_end_o, sample_idx_o,
               frame_cnt_o, align_busy_o, align_done_o, offset_err_o
    );
endinterface

// File: rtl/sync_align.sv
// sync_align: waits for the sync offset stage to report an offset, drops that
// many leading samples, then re-emits the ECG stream as back-to-back frames of
// TMP_WINDOW_LENGTH samples with start/end strobes, an in-frame index and a
// saturating frame counter. A run ends after NUM_FRAMES frames (0 = never).
module sync_align #(
    parameter int DATA_W            = 16,
    parameter int TMP_WINDOW_LENGTH = 800,
    parameter int LOG2_WIN          = 10,
    parameter int NUM_FRAMES        = 8,
    parameter int FRAME_CNT_W       = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        align_clr,
    sync_align_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SKIP   = 2'd1,
        STREAM = 2'd2
    } state_t;

    localparam logic [DATA_W-1:0]   WIN_D    = DATA_W'(TMP_WINDOW_LENGTH);
    localparam logic [LOG2_WIN-1:0] IDX_LAST = LOG2_WIN'(TMP_WINDOW_LENGTH - 1);

    state_t              state;
    logic [LOG2_WIN-1:0] off_r;
    logic [LOG2_WIN-1:0] skip_cnt;
    logic [LOG2_WIN-1:0] idx;

    // Offsets that would skip a whole window or more are pulled back to the
    // last in-window position, so off_r always fits the index width.
    function automatic logic [LOG2_WIN-1:0] clamp_offset(input logic [DATA_W-1:0] off);
        if (off >= WIN_D) return IDX_LAST;
        return off[LOG2_WIN-1:0];
    endfunction

    // Frame counter sticks at all-ones instead of wrapping.
    function automatic logic [FRAME_CNT_W-1:0] sat_inc(input logic [FRAME_CNT_W-1:0] v);
        return (&v) ? v : v + FRAME_CNT_W'(1);
    endfunction

    // True when the frame ending now is frame NUM_FRAMES of the run. The
    // compare is done one bit wider than the counter so a full counter does
    // not alias back to a small frame number.
    function automatic logic run_complete(input logic [FRAME_CNT_W-1:0] cnt);
        if (NUM_FRAMES == 0) return 1'b0;
        return ({1'b0, cnt} + (FRAME_CNT_W+1)'(1)) == (FRAME_CNT_W+1)'(NUM_FRAMES);
    endfunction

    // Control FSM together with the registered output stage (1 clk latency)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= IDLE;
            off_r             <= '0;
            skip_cnt          <= '0;
            idx               <= '0;
            bus.data_vld_o    <= 1'b0;
            bus.data_o        <= '0;
            bus.frame_start_o <= 1'b0;
            bus.frame_end_o   <= 1'b0;
            bus.sample_idx_o  <= '0;
            bus.frame_cnt_o   <= '0;
            bus.align_busy_o  <= 1'b0;
            bus.align_done_o  <= 1'b0;
            bus.offset_err_o  <= 1'b0;
        end else if (align_clr) begin
            state             <= IDLE;
            off_r             <= '0;
            skip_cnt          <= '0;
            idx               <= '0;
            bus.data_vld_o    <= 1'b0;
            bus.data_o        <= '0;
            bus.frame_start_o <= 1'b0;
            bus.frame_end_o   <= 1'b0;
            bus.sample_idx_o  <= '0;
            bus.frame_cnt_o   <= '0;
            bus.align_busy_o  <= 1'b0;
            bus.align_done_o  <= 1'b0;
            bus.offset_err_o  <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-asserted below
            bus.data_vld_o    <= 1'b0;
            bus.frame_start_o <= 1'b0;
            bus.frame_end_o   <= 1'b0;
            bus.align_done_o  <= 1'b0;

            case (state)
                IDLE: begin
                    // Busy stays up through the cycle carrying the final
                    // frame end and drops on the first full idle cycle.
                    bus.align_busy_o <= bus.offset_vld;
                    if (bus.offset_vld) begin
                        off_r           <= clamp_offset(bus.offset_i);
                        skip_cnt        <= '0;
                        idx             <= '0;
                        bus.frame_cnt_o <= '0;
                        if (bus.offset_i >= WIN_D) bus.offset_err_o <= 1'b1;
                        // The sample arriving with offset_vld is never counted
                        state <= (clamp_offset(bus.offset_i) == '0) ? STREAM : SKIP;
                    end
                end

                SKIP: begin
                    if (bus.data_vld_i) begin
                        if (skip_cnt == off_r - LOG2_WIN'(1)) begin
                            skip_cnt <= '0;
                            state    <= STREAM;
                        end else begin
                            skip_cnt <= skip_cnt + LOG2_WIN'(1);
                        end
                    end
                end

                STREAM: begin
                    if (bus.data_vld_i) begin
                        bus.data_vld_o    <= 1'b1;
                        bus.data_o        <= bus.data_i;
                        bus.sample_idx_o  <= idx;
                        bus.frame_start_o <= (idx == '0);
                        if (idx == IDX_LAST) begin
                            bus.frame_end_o <= 1'b1;
                            bus.frame_cnt_o <= sat_inc(bus.frame_cnt_o);
                            idx             <= '0;
                            if (run_complete(bus.frame_cnt_o)) begin
                                bus.align_done_o <= 1'b1;
                                state            <= IDLE;
                            end
                        end else begin
                            idx <= idx + LOG2_WIN'(1);
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sync_align.sv
// Bench for sync_align: a count-based reference model (samples still to skip,
// samples emitted so far in the run) predicts every output each cycle; a few
// directed values from the test plan are checked on top of that.
module tb_sync_align;
    localparam int DW  = 16;
    localparam int WIN = 800;
    localparam int L2  = 10;
    localparam int NF  = 2;
    localparam int FCW = 8;

    logic clk       = 1'b0;
    logic reset_n   = 1'b0;
    logic align_clr = 1'b0;

    always #5 clk = ~clk;

    sync_align_if #(.DATA_W(DW), .LOG2_WIN(L2), .FRAME_CNT_W(FCW)) bus ();

    sync_align #(
        .DATA_W(DW), .TMP_WINDOW_LENGTH(WIN), .LOG2_WIN(L2),
        .NUM_FRAMES(NF), .FRAME_CNT_W(FCW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .align_clr(align_clr), .bus(bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit                    m_run;
    int                    m_skip;
    int                    m_n;
    bit                    m_err;
    logic                  e_vld, e_start, e_end, e_done, e_busy, e_err;
    logic signed [DW-1:0]  e_data;
    logic [L2-1:0]         e_idx;
    logic [FCW-1:0]        e_cnt;

    // Observation log for directed checks
    bit          got_first, got_end, done_seen, prev_done;
    logic [31:0] first_data, first_start, first_idx, end_data, end_cnt;
    logic [31:0] done_data, done_cnt, busy_after;
    int          n_out, out_after_done;

    task automatic model_clear();
        m_run = 0; m_skip = 0; m_n = 0; m_err = 0;
        e_vld = 0; e_start = 0; e_end = 0; e_done = 0; e_busy = 0; e_err = 0;
        e_data = '0; e_idx = '0; e_cnt = '0;
    endtask

    task automatic model_step(input bit ov, input logic [DW-1:0] oi, input bit dv,
                              input logic signed [DW-1:0] d, input bit clr, input bit rst_low);
        if (clr || rst_low) begin
            model_clear();
            return;
        end
        e_vld = 0; e_start = 0; e_end = 0; e_done = 0;
        if (!m_run) begin
            e_busy = ov;
            if (ov) begin
                m_run  = 1;
                m_err  = m_err | (int'(oi) >= WIN);
                m_skip = (int'(oi) >= WIN) ? WIN - 1 : int'(oi);
                m_n    = 0;
                e_cnt  = '0;
            end
        end else if (dv) begin
            if (m_skip > 0) begin
                m_skip--;
            end else begin
                e_vld   = 1;
                e_data  = d;
                e_idx   = L2'(m_n % WIN);
                e_start = (m_n % WIN == 0);
                e_end   = (m_n % WIN == WIN - 1);
                m_n++;
                if (e_end) begin
                    e_cnt = (m_n / WIN > 255) ? 8'hFF : FCW'(m_n / WIN);
                    if (NF != 0 && m_n == NF * WIN) begin
                        e_done = 1;
                        m_run  = 0;
                    end
                end
            end
        end
        e_err = m_err;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("data_vld_o",    32'(bus.data_vld_o),    32'(e_vld));
        chk("data_o",        32'(bus.data_o),        32'(e_data));
        chk("frame_start_o", 32'(bus.frame_start_o), 32'(e_start));
        chk("frame_end_o",   32'(bus.frame_end_o),   32'(e_end));
        chk("sample_idx_o",  32'(bus.sample_idx_o),  32'(e_idx));
        chk("frame_cnt_o",   32'(bus.frame_cnt_o),   32'(e_cnt));
        chk("align_busy_o",  32'(bus.align_busy_o),  32'(e_busy));
        chk("align_done_o",  32'(bus.align_done_o),  32'(e_done));
        chk("offset_err_o",  32'(bus.offset_err_o),  32'(e_err));
    endtask

    task automatic arm();
        got_first = 0; got_end = 0; done_seen = 0; prev_done = 0;
        first_data = '1; first_start = '1; first_idx = '1;
        end_data = '1; end_cnt = '1; done_data = '1; done_cnt = '1; busy_after = '1;
        n_out = 0; out_after_done = 0;
    endtask

    task automatic record();
        if (prev_done) busy_after = 32'(bus.align_busy_o);
        prev_done = bus.align_done_o;
        if (bus.data_vld_o) begin
            n_out++;
            if (done_seen) out_after_done++;
            if (!got_first) begin
                got_first   = 1;
                first_data  = 32'(bus.data_o);
                first_start = 32'(bus.frame_start_o);
                first_idx   = 32'(bus.sample_idx_o);
            end
        end
        if (bus.frame_end_o && !got_end) begin
            got_end  = 1;
            end_data = 32'(bus.data_o);
            end_cnt  = 32'(bus.frame_cnt_o);
        end
        if (bus.align_done_o) begin
            done_seen = 1;
            done_data = 32'(bus.data_o);
            done_cnt  = 32'(bus.frame_cnt_o);
        end
    endtask

    // One clock: drive inputs after the falling edge, advance the model on the
    // rising edge, compare everything on the next falling edge.
    task automatic tick(input bit ov, input logic [DW-1:0] oi, input bit dv,
                        input logic signed [DW-1:0] d);
        bus.offset_vld = ov;
        bus.offset_i   = oi;
        bus.data_vld_i = dv;
        bus.data_i     = d;
        @(posedge clk);
        model_step(ov, oi, dv, d, align_clr, !reset_n);
        @(negedge clk);
        check_all();
        record();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.offset_vld = 1'b0;
        bus.offset_i   = '0;
        bus.data_vld_i = 1'b0;
        bus.data_i     = '0;
        model_clear();

        // Reset state
        repeat (2) @(negedge clk);
        check_all();
        reset_n = 1'b1;
        repeat (3) tick(1'b0, 16'd0, 1'b0, 16'sd0);

        // Basic alignment, offset 50, continuous ramp
        arm();
        tick(1'b1, 16'd50, 1'b1, 16'sd0);
        for (int i = 1; i <= 1700; i++) tick(1'b0, 16'd0, 1'b1, 16'(i));
        chk("basic_first_data",  first_data,  32'd51);
        chk("basic_first_start", first_start, 32'd1);
        chk("basic_first_idx",   first_idx,   32'd0);
        chk("basic_end_data",    end_data,    32'd850);
        chk("basic_end_cnt",     end_cnt,     32'd1);

        // Run completion, offset 10
        arm();
        tick(1'b1, 16'd10, 1'b1, 16'sd0);
        for (int i = 1; i <= 1640; i++) tick(1'b0, 16'd0, 1'b1, 16'(i));
        chk("done_data",      done_data,      32'd1610);
        chk("done_cnt",       done_cnt,       32'd2);
        chk("done_busy_next", busy_after,     32'd0);
        chk("done_n_out",     32'(n_out),     32'd1600);
        chk("done_no_more",   32'(out_after_done), 32'd0);

        // Zero offset: STREAM directly, next-cycle sample is the frame start
        arm();
        tick(1'b1, 16'd0, 1'b1, 16'sd0);
        for (int i = 1; i <= 20; i++) tick(1'b0, 16'd0, 1'b1, 16'(i));
        chk("zero_first_data",  first_data,  32'd1);
        chk("zero_first_start", first_start, 32'd1);
        align_clr = 1'b1;
        tick(1'b0, 16'd0, 1'b1, 16'sd21);
        align_clr = 1'b0;

        // Bad offset: clamped to 799 skips, error sticky until clear
        arm();
        tick(1'b1, 16'd900, 1'b1, 16'sd0);
        for (int i = 1; i <= 820; i++) tick(1'b0, 16'd0, 1'b1, 16'(i));
        chk("bad_first_data", first_data, 32'd800);
        chk("bad_err_sticky", 32'(bus.offset_err_o), 32'd1);
        align_clr = 1'b1;
        tick(1'b1, 16'd5, 1'b1, 16'sd0);
        align_clr = 1'b0;
        chk("clr_err",  32'(bus.offset_err_o), 32'd0);
        chk("clr_busy", 32'(bus.align_busy_o), 32'd0);

        // Stalls: valid every other cycle, random data, stray offset_vld in STREAM
        arm();
        tick(1'b1, 16'd50, 1'b1, 16'($urandom));
        for (int i = 1; i <= 3400; i++) begin
            tick((i == 500), 16'd5, bit'(i % 2), 16'($urandom));
        end
        chk("stall_n_out", 32'(n_out), 32'd1600);
        chk("stall_done",  32'(done_seen), 32'd1);

        // Async reset mid-STREAM, then a clean restart
        arm();
        tick(1'b1, 16'd20, 1'b1, 16'($urandom));
        for (int i = 1; i <= 100; i++) tick(1'b0, 16'd0, 1'b1, 16'($urandom));
        #2;
        reset_n = 1'b0;
        #1;
        model_clear();
        check_all();
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        arm();
        tick(1'b1, 16'd3, 1'b1, 16'sd0);
        for (int i = 1; i <= 30; i++) tick(1'b0, 16'd0, 1'b1, 16'(i));
        chk("restart_first_data", first_data, 32'd4);
        chk("restart_first_idx",  first_idx,  32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sync_align.md
Name: sync_align

Overview:
- Downstream consumer of the sync offset stage.
- Once the offset stage reports its done pulse and offset value, this block drops that many leading input samples.
- It then re-emits the ECG sample stream as back-to-back aligned windows of TMP_WINDOW_LENGTH samples, with frame start/end strobes and a frame counter.
- Feature-extraction stages downstream consume these aligned frames.

Parameters:
- DATA_W, 16: sample and offset width.
- TMP_WINDOW_LENGTH, 800: samples per aligned frame.
- LOG2_WIN, 10: width of the in-frame sample index; must satisfy 2^LOG2_WIN >= TMP_WINDOW_LENGTH.
- NUM_FRAMES, 8: frames emitted per alignment run; 0 = unbounded.
- FRAME_CNT_W, 8: width of the frame counter.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- align_clr  in  1  synchronous clear; returns block to IDLE.
- offset_vld  in  1  one-cycle pulse, driven from the offset stage's done strobe.
- offset_i  in  DATA_W  sample offset, valid with offset_vld.
- data_vld_i  in  1  input sample strobe.
- data_i  in  DATA_W (signed)  input ECG sample.
- data_vld_o  out  1  aligned sample strobe.
- data_o  out  DATA_W (signed)  aligned sample.
- frame_start_o  out  1  high with first sample of each frame.
- frame_end_o  out  1  high with last sample of each frame.
- sample_idx_o  out  LOG2_WIN  in-frame index of data_o.
- frame_cnt_o  out  FRAME_CNT_W  frames completed this run; saturating.
- align_busy_o  out  1  high in SKIP or STREAM.
- align_done_o  out  1  one-cycle pulse when NUM_FRAMES frames have completed.
- offset_err_o  out  1  sticky; set when offset_i >= TMP_WINDOW_LENGTH.

Behaviour:
- Reset (async, reset_n low):
  - All outputs are 0.
  - FSM state = IDLE; internal skip counter, index and offset registers = 0.
- align_clr: same effect as reset but synchronous. It has priority over every other input in the same cycle and also clears offset_err_o.
- FSM states: IDLE, SKIP, STREAM.
- IDLE:
  - data_vld_o = 0; all input samples are discarded.
  - On offset_vld: latch offset_i into off_r.
  - If offset_i >= TMP_WINDOW_LENGTH: set offset_err_o and clamp off_r to TMP_WINDOW_LENGTH-1.
  - If the latched (clamped) value is 0, go to STREAM; otherwise go to SKIP.
  - A sample with data_vld_i in the same cycle as offset_vld is discarded and not counted; counting starts the following cycle.
- SKIP:
  - Each data_vld_i increments skip_cnt.
  - When data_vld_i arrives with skip_cnt == off_r-1, that sample is dropped and the FSM moves to STREAM.
  - Exactly off_r samples are dropped; no output is produced.
- STREAM:
  - Each data_vld_i registers data_i to data_o, with data_vld_o asserted the next cycle. Latency is 1 clk.
  - sample_idx_o carries the current idx; idx then increments.
  - frame_start_o is asserted when idx == 0; frame_end_o when idx == TMP_WINDOW_LENGTH-1.
  - At frame end: idx wraps to 0 and frame_cnt_o increments, saturating at all-ones.
  - If NUM_FRAMES != 0 and this end completes frame NUM_FRAMES:
    - assert align_done_o with the frame_end_o cycle;
    - return to IDLE;
    - frame_cnt_o holds its value until the next offset_vld, which clears it to 0.
  - Gaps in data_vld_i stall the FSM; output strobes stay low during gaps.
- offset_vld is ignored outside IDLE.
- Strobe behaviour: data_vld_o, frame_start_o, frame_end_o and align_done_o are single-cycle strobes aligned with data_o. frame_start_o and frame_end_o are never both high when TMP_WINDOW_LENGTH > 1.
- align_busy_o is registered and follows the state: high from the cycle after offset_vld until the cycle after the final frame_end_o.

Test Plan:
- Basic alignment (continuous data_vld_i, data_i = ramp 0,1,2..., offset_vld with offset_i=50): first data_o = 51 (the cycle-0 sample and 50 skipped), carried with frame_start_o and sample_idx_o = 0. frame_end_o arrives on data_o = 850. frame_cnt_o = 1 after it.
- Zero offset (offset_i=0): STREAM is entered directly; the sample arriving the cycle after offset_vld appears one clk later with frame_start_o.
- Run completion (NUM_FRAMES=2, offset_i=10, ramp input):
  - align_done_o pulses together with the second frame_end_o (data_o = 1610);
  - block returns to IDLE; frame_cnt_o = 2; align_busy_o = 0 one cycle later;
  - further samples produce no output.
- Bad offset (offset_i=900): offset_err_o = 1; exactly 799 samples are skipped; offset_err_o stays set until align_clr.
- Stalls and clear:
  - data_vld_i toggles every other cycle during SKIP and STREAM: skipped and emitted counts match the continuous case, and output only appears on valid cycles.
  - reset_n is pulsed low mid-STREAM: all outputs drop to 0 immediately, and a fresh offset_vld restarts cleanly.
  - offset_vld during STREAM has no effect.
